// File: rtl/tinker_pkg.sv
// Shared types and constants for the Tinker fetch stage.
package tinker_pkg;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned INSTR_W = 32;

    localparam logic [4:0]        OP_HALT          = 5'h0f;
    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 64'h2000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return (instr[31:27] == OP_HALT) && (instr[3:0] == 4'h0);
    endfunction

endpackage

// File: rtl/tinker_fetch_if.sv
// Instruction-memory, redirect and decode-side signals of the fetch stage.
interface tinker_fetch_if;
    import tinker_pkg::*;

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               id_valid;
    logic               id_ready;
    logic [ADDR_W-1:0]  id_pc;
    logic [INSTR_W-1:0] id_instr;
    logic               hlt;

    modport master (
        output imem_req, imem_addr, id_valid, id_pc, id_instr, hlt,
        input  imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_pc, id_instr, hlt,
        output imem_rdata, redirect_valid, redirect_pc, id_ready
    );

endinterface

// File: rtl/tinker_fetch_fifo.sv
// Fetch buffer: synchronous FIFO of {pc, instr} entries; flush wins over push.
module fetch_fifo
    import tinker_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  fetch_entry_t entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic         empty_o,
    output logic         full_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q   <= '{default: '0};
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= entry_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_i) begin
                rd_q <= rd_q + 1'b1;
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/tinker_fetch.sv
// Tinker instruction-fetch stage: PC, request issue, response buffering, redirect and halt.
module tinker_fetch
    import tinker_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic           clk,
    input  logic           reset,
    tinker_fetch_if.master bus
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OW = CW + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q;
    logic              inflight_q;
    logic              halted_q;

    fetch_entry_t  head;
    logic [CW-1:0] count;
    logic          empty, full;
    logic          redirect, id_valid, pop, halt_pop, flush, push, can_issue, req;

    // Halted stage ignores redirects entirely; reset gating keeps outputs quiet while held.
    assign redirect  = reset && bus.redirect_valid && !halted_q;
    assign id_valid  = reset && !empty && !halted_q && !redirect;
    assign pop       = id_valid && bus.id_ready;
    assign halt_pop  = pop && is_halt(head.instr);
    assign flush     = redirect || halt_pop;
    assign push      = inflight_q && !halted_q && !full;

    // occupancy + inflight - pop < depth, rearranged to avoid unsigned underflow
    assign can_issue = (OW'(count) + OW'(inflight_q)) < (OW'(FIFO_DEPTH) + OW'(pop));
    assign req       = reset && !halted_q && !bus.redirect_valid && can_issue;

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = bus.redirect_pc & ~ADDR_W'(3);
        end else if (req) begin
            pc_d = pc_q + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= req;
            if (req) begin
                req_pc_q <= pc_q;
            end
            if (halt_pop) begin
                halted_q <= 1'b1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .entry_i ('{pc: req_pc_q, instr: bus.imem_rdata}),
        .pop_i   (pop),
        .flush_i (flush),
        .head_o  (head),
        .count_o (count),
        .empty_o (empty),
        .full_o  (full)
    );

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;
    assign bus.id_valid  = id_valid;
    assign bus.id_pc     = head.pc;
    assign bus.id_instr  = head.instr;
    assign bus.hlt       = halted_q;

endmodule

// File: tb/tb_tinker_fetch.sv
// Directed bench for tinker_fetch with a word-per-cycle instruction memory model.
module tb_tinker_fetch;
    import tinker_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    tinker_fetch_if bus();

    tinker_fetch #(
        .RESET_PC   (64'h2000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [63:0] halt_addr = 64'h1;
    logic [63:0] pcs[$];
    logic [31:0] ins[$];

    function automatic logic [31:0] word(input logic [63:0] a);
        if (a == halt_addr) return 32'h7800_0000;
        return a[31:0] ^ 32'h5A5A_0001;
    endfunction

    always @(posedge clk) bus.imem_rdata <= word(bus.imem_addr);

    always @(negedge clk) begin
        if (reset && bus.id_valid && bus.id_ready) begin
            pcs.push_back(bus.id_pc);
            ins.push_back(bus.id_instr);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) tick();
    endtask

    task automatic restart(input logic rdy);
        reset              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.id_ready       = rdy;
        repeat (2) tick();
        reset = 1'b1;
        cyc   = 0;
        pcs.delete();
        ins.delete();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=%0d exp=finish", cyc);
        $fatal(1);
    end

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_ready       = 1'b1;

        // reset values, then first fetch timing
        repeat (2) tick();
        check("rst_req",   bus.imem_req,  0);
        check("rst_valid", bus.id_valid,  0);
        check("rst_hlt",   bus.hlt,       0);
        check("rst_addr",  bus.imem_addr, 64'h2000);
        check("rst_pc",    bus.id_pc,     0);
        check("rst_instr", bus.id_instr,  0);
        reset = 1'b1;
        cyc   = 0;
        #1;
        check("c0_req",   bus.imem_req,  1);
        check("c0_addr",  bus.imem_addr, 64'h2000);
        check("c0_valid", bus.id_valid,  0);
        goto(1);
        check("c1_valid", bus.id_valid,  0);
        goto(2);
        check("c2_valid", bus.id_valid,  1);
        check("c2_pc",    bus.id_pc,     64'h2000);
        check("c2_instr", bus.id_instr,  32'h5A5A_2001);
        goto(3);
        check("c3_pc",    bus.id_pc,     64'h2004);
        goto(4);
        check("c4_pc",    bus.id_pc,     64'h2008);

        // decode stall from cycle 0, released at cycle 7
        restart(1'b0);
        check("st0_req", bus.imem_req, 1);
        goto(2);
        check("st2_req", bus.imem_req, 0);
        check("st2_pc",  bus.id_pc,    64'h2000);
        goto(6);
        check("st6_req",   bus.imem_req, 0);
        check("st6_pc",    bus.id_pc,    64'h2000);
        check("st6_instr", bus.id_instr, 32'h5A5A_2001);
        goto(7);
        bus.id_ready = 1'b1;
        #1;
        check("st7_req", bus.imem_req, 1);
        goto(12);
        check("st_n",  pcs.size(), 5);
        check("st_p0", pcs[0], 64'h2000);
        check("st_p1", pcs[1], 64'h2004);
        check("st_p4", pcs[4], 64'h2010);

        // redirect to an unaligned target in cycle 5
        restart(1'b1);
        goto(5);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h3003;
        #1;
        check("rd5_valid", bus.id_valid, 0);
        check("rd5_req",   bus.imem_req, 0);
        goto(6);
        bus.redirect_valid = 1'b0;
        #1;
        check("rd6_addr",  bus.imem_addr, 64'h3000);
        check("rd6_req",   bus.imem_req,  1);
        goto(7);
        check("rd7_valid", bus.id_valid,  0);
        goto(8);
        check("rd8_valid", bus.id_valid,  1);
        check("rd8_pc",    bus.id_pc,     64'h3000);
        goto(10);
        check("rd_n",  pcs.size(), 5);
        check("rd_p2", pcs[2], 64'h2008);
        check("rd_p3", pcs[3], 64'h3000);

        // halt word at 0x2008, later redirect must be ignored
        halt_addr = 64'h2008;
        restart(1'b1);
        goto(4);
        check("h4_pc",    bus.id_pc,    64'h2008);
        check("h4_hlt",   bus.hlt,      0);
        goto(5);
        check("h5_hlt",   bus.hlt,      1);
        check("h5_valid", bus.id_valid, 0);
        check("h5_req",   bus.imem_req, 0);
        goto(7);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h4000;
        #1;
        check("h7_req", bus.imem_req, 0);
        goto(8);
        bus.redirect_valid = 1'b0;
        #1;
        check("h8_addr",  bus.imem_addr, 64'h2014);
        check("h8_valid", bus.id_valid,  0);
        goto(12);
        check("h_hlt",  bus.hlt,    1);
        check("h_n",    pcs.size(), 3);
        check("h_ins2", ins[2],     32'h7800_0000);

        // reset while halted
        reset = 1'b0;
        tick();
        check("hr_req",   bus.imem_req,  0);
        check("hr_valid", bus.id_valid,  0);
        check("hr_hlt",   bus.hlt,       0);
        check("hr_addr",  bus.imem_addr, 64'h2000);
        check("hr_pc",    bus.id_pc,     0);
        halt_addr = 64'h1;
        reset     = 1'b1;
        cyc       = 0;
        #1;
        goto(2);
        check("hr2_valid", bus.id_valid, 1);
        check("hr2_pc",    bus.id_pc,    64'h2000);

        // PC wrap past the top of the address space
        restart(1'b1);
        goto(3);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        goto(4);
        bus.redirect_valid = 1'b0;
        goto(6);
        check("w6_valid", bus.id_valid, 1);
        check("w6_pc",    bus.id_pc,    64'hFFFF_FFFF_FFFF_FFFC);
        goto(7);
        check("w7_pc",    bus.id_pc,    64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
